// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin scheduler that shares one FIFO write port between NUM_REQ
//   producers in the write clock domain. Each grant is a burst of up to
//   MAX_BURST words, or a single word when the FIFO is half full at grant
//   time. Writes stall while the FIFO is full.
// Ports
//   wclk, wrst     write clock, synchronous active-high reset
//   req_valid      per-producer word-available flags
//   req_data       packed producer words, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-producer accept (valid & ready = word taken)
//   wfull          FIFO full flag
//   half_full      FIFO half-full flag, sampled only at grant
//   data_write     FIFO write data (zero when not writing)
//   write_enable   FIFO write strobe
//   grant_id       current or most recent granted producer
//   busy           high while a burst is in progress
//   words_written  wrapping count of FIFO writes since reset
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    input  logic                          half_full,
    output logic [DATA_WIDTH-1:0]         data_write,
    output logic                          write_enable,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          words_written
);

    localparam int          GW = $clog2(NUM_REQ);
    localparam int          BW = $clog2(MAX_BURST + 1);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nx;
    logic [GW-1:0]         rr_last;
    logic [GW-1:0]         pick;
    logic                  pick_ok;
    logic [BW-1:0]         burst_cnt;
    logic [BW-1:0]         burst_lim;
    logic                  fire;
    logic                  start;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last granted requester, wrapping around.
    always_comb begin : arb
        int unsigned idx;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = (32'(rr_last) + k) % NR;
            if (!pick_ok && req_valid[GW'(idx)]) begin
                pick    = GW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready    = '0;
        write_enable = 1'b0;
        data_write   = '0;
        busy         = 1'b0;
        fire         = 1'b0;
        start        = 1'b0;
        burst_end    = 1'b0;
        if (!wrst) begin
            case (state)
                IDLE: begin
                    if (pick_ok && !wfull) begin
                        start    = 1'b1;
                        state_nx = BURST;
                    end
                end
                BURST: begin
                    busy                = 1'b1;
                    req_ready[grant_id] = !wfull;
                    fire                = req_valid[grant_id] && !wfull;
                    write_enable        = fire;
                    if (fire) data_write = words[grant_id];
                    // A stalled-but-valid requester keeps the grant; a dropped
                    // valid ends the burst even while the FIFO is full.
                    if (!req_valid[grant_id] ||
                        (fire && (burst_cnt + BW'(1)) == burst_lim)) begin
                        burst_end = 1'b1;
                        state_nx  = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            grant_id      <= '0;
            rr_last       <= GW'(NUM_REQ - 1);
            burst_cnt     <= '0;
            burst_lim     <= BW'(MAX_BURST);
            words_written <= '0;
        end else begin
            if (start) begin
                grant_id  <= pick;
                burst_cnt <= '0;
                burst_lim <= half_full ? BW'(1) : BW'(MAX_BURST);
            end
            if (fire) begin
                burst_cnt     <= burst_cnt + BW'(1);
                words_written <= words_written + CNT_WIDTH'(1);
            end
            if (burst_end) rr_last <= grant_id;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 4;

    logic              wclk = 1'b0;
    logic              wrst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wfull;
    logic              half_full;
    logic [DW-1:0]     data_write;
    logic              write_enable;
    logic [1:0]        grant_id;
    logic              busy;
    logic [CW-1:0]     words_written;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
    ) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .half_full(half_full),
        .data_write(data_write), .write_enable(write_enable),
        .grant_id(grant_id), .busy(busy), .words_written(words_written)
    );

    int checks = 0;
    int errors = 0;

    // Producers: word = {id, sequence number}; sequence advances on handshake.
    int unsigned seq  [NR];
    int unsigned mcnt [NR];

    // Reference model of the grant/burst rules.
    bit          m_burst;
    int unsigned m_owner, m_last, m_taken, m_limit, m_total;

    int unsigned gq[$];
    bit          prev_busy = 1'b0;
    int unsigned we_seen;

    function automatic logic [DW-1:0] word_of(input int unsigned i);
        return DW'((i << 6) | (seq[i] & 63));
    endfunction

    task automatic model_reset();
        m_burst = 1'b0; m_owner = 0; m_last = NR - 1;
        m_taken = 0;    m_limit = MB; m_total = 0;
    endtask

    task automatic tick(input string tag);
        logic [NR-1:0] e_rdy;
        logic [DW-1:0] e_dw;
        logic          e_we, e_busy;
        bit            fire, found;
        bit [NR-1:0]   hs;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i);
        #1;
        e_rdy = '0; e_dw = '0; e_we = 1'b0; e_busy = 1'b0; fire = 1'b0;
        if (!wrst && m_burst) begin
            e_busy = 1'b1;
            if (!wfull) e_rdy[m_owner] = 1'b1;
            fire = req_valid[m_owner] && !wfull;
            e_we = fire;
            if (fire) e_dw = word_of(m_owner);
        end
        checks++; if (write_enable !== e_we) begin errors++;
            $display("FAIL %s write_enable: got %b expected %b", tag, write_enable, e_we); end
        checks++; if (data_write !== e_dw) begin errors++;
            $display("FAIL %s data_write: got %h expected %h", tag, data_write, e_dw); end
        checks++; if (req_ready !== e_rdy) begin errors++;
            $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, e_rdy); end
        checks++; if (busy !== e_busy) begin errors++;
            $display("FAIL %s busy: got %b expected %b", tag, busy, e_busy); end
        checks++; if (grant_id !== 2'(m_owner)) begin errors++;
            $display("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, m_owner); end
        checks++; if (words_written !== CW'(m_total)) begin errors++;
            $display("FAIL %s words_written: got %0d expected %0d", tag, words_written, m_total % 16); end

        if (busy === 1'b1 && !prev_busy) gq.push_back(32'(grant_id));
        prev_busy = (busy === 1'b1);
        if (write_enable === 1'b1) we_seen++;
        for (int i = 0; i < NR; i++) hs[i] = (req_valid[i] && req_ready[i] === 1'b1);

        @(posedge wclk);
        for (int i = 0; i < NR; i++) if (hs[i]) seq[i]++;
        if (wrst) model_reset();
        else if (m_burst) begin
            if (!req_valid[m_owner]) begin
                m_burst = 1'b0; m_last = m_owner;
            end else if (!wfull) begin
                m_taken++; m_total = (m_total + 1) % 16; mcnt[m_owner]++;
                if (m_taken == m_limit) begin m_burst = 1'b0; m_last = m_owner; end
            end
        end else if (req_valid != '0 && !wfull) begin
            found = 1'b0;
            for (int unsigned k = 1; k <= NR; k++)
                if (!found && req_valid[(m_last + k) % NR]) begin
                    found = 1'b1; m_owner = (m_last + k) % NR;
                end
            m_taken = 0; m_limit = half_full ? 1 : MB; m_burst = 1'b1;
        end
        @(negedge wclk);
    endtask

    task automatic check_grants(input string tag, input int unsigned exp[$]);
        checks++;
        if (gq.size() != exp.size()) begin errors++;
            $display("FAIL %s grant_count: got %0d expected %0d", tag, gq.size(), exp.size());
        end else begin
            foreach (exp[j]) begin
                checks++;
                if (gq[j] != exp[j]) begin errors++;
                    $display("FAIL %s grant[%0d]: got %0d expected %0d", tag, j, gq[j], exp[j]); end
            end
        end
    endtask

    task automatic test_reset();
        wrst = 1'b1; req_valid = '1; wfull = 1'b0; half_full = 1'b0;
        @(posedge wclk); @(negedge wclk);
        model_reset();
        tick("reset0"); tick("reset1");
        checks++; if (words_written !== '0 || grant_id !== 2'd0) begin errors++;
            $display("FAIL reset_values: got ww=%0d gid=%0d expected ww=0 gid=0", words_written, grant_id); end
        wrst = 1'b0;
    endtask

    task automatic test_round_robin();
        gq.delete(); we_seen = 0;
        req_valid = '1;
        for (int t = 0; t < 25; t++) tick("round_robin");
        check_grants("round_robin", '{0, 1, 2, 3, 0});
        checks++; if (we_seen != 20) begin errors++;
            $display("FAIL round_robin writes: got %0d expected 20", we_seen); end
    endtask

    task automatic test_short_burst();
        gq.delete(); we_seen = 0;
        req_valid = 4'b1100;
        for (int t = 0; t < 3; t++) tick("short_burst");
        req_valid = 4'b1000;
        for (int t = 0; t < 3; t++) tick("short_burst");
        req_valid = '0;
        for (int t = 0; t < 2; t++) tick("short_burst");
        check_grants("short_burst", '{2, 3});
        checks++; if (we_seen != 3) begin errors++;
            $display("FAIL short_burst writes: got %0d expected 3", we_seen); end
    endtask

    task automatic test_full_stall();
        gq.delete(); we_seen = 0;
        req_valid = 4'b0010;
        for (int t = 0; t < 3; t++) tick("full_stall");
        wfull = 1'b1;
        for (int t = 0; t < 3; t++) tick("full_stall_hold");
        wfull = 1'b0;
        for (int t = 0; t < 2; t++) tick("full_stall");
        req_valid = '0;
        for (int t = 0; t < 2; t++) tick("full_stall");
        check_grants("full_stall", '{1});
        checks++; if (we_seen != 4) begin errors++;
            $display("FAIL full_stall writes: got %0d expected 4", we_seen); end
    endtask

    task automatic test_throttle();
        gq.delete(); we_seen = 0;
        req_valid = '1; half_full = 1'b1;
        tick("throttle");
        half_full = 1'b0; wfull = 1'b1;
        tick("throttle_hold");
        half_full = 1'b1; wfull = 1'b0;
        for (int t = 0; t < 7; t++) tick("throttle");
        half_full = 1'b0; req_valid = '0;
        tick("throttle");
        check_grants("throttle", '{2, 3, 0, 1});
        checks++; if (we_seen != 4) begin errors++;
            $display("FAIL throttle writes: got %0d expected 4", we_seen); end
    endtask

    task automatic test_counter_wrap();
        wrst = 1'b1; req_valid = '1;
        tick("wrap_reset"); tick("wrap_reset");
        wrst = 1'b0; we_seen = 0;
        for (int t = 0; t < 60 && we_seen < 17; t++) tick("wrap");
        req_valid = '0;
        checks++; if (we_seen != 17) begin errors++;
            $display("FAIL wrap budget: got %0d writes expected 17", we_seen); end
        checks++; if (words_written !== 4'd1) begin errors++;
            $display("FAIL wrap words_written: got %0d expected 1", words_written); end
        for (int t = 0; t < 3; t++) tick("wrap_drain");
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            wrst      = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
            wfull     = ($urandom_range(0, 4) == 0);
            half_full = ($urandom_range(0, 2) == 0);
            tick("random");
        end
        wrst = 1'b0; wfull = 1'b0; half_full = 1'b0; req_valid = '0;
        for (int t = 0; t < 3; t++) tick("random_drain");
        for (int i = 0; i < NR; i++) begin
            checks++; if (seq[i] != mcnt[i]) begin errors++;
                $display("FAIL accepted_words[%0d]: got %0d expected %0d", i, seq[i], mcnt[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin seq[i] = 0; mcnt[i] = 0; end
        req_data = '0;
        test_reset();
        test_round_robin();
        test_short_burst();
        test_full_stall();
        test_throttle();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
